ce_write_scheduler: RTL and testbench
=====================================

Name: ce_write_scheduler

Overview:
- Parametrised successor to the top-level clock-enable divider and single-entry loader-write latch.
- Generates the divided core clock-enable (CE_DIV slots per period).
- Captures write strobes from NCH independent sources (loader, save-RAM restore, debug) into per-channel holding registers, then into a shared FIFO of DEPTH entries.
- Issues exactly one SDRAM write per CE period, aligned to a fixed slot, so bursts of strobes faster than one per CE period are queued, not dropped.

Parameters:
- CE_DIV, 4: clock-enable period in clk cycles (>=2).
- CE_PHASE, 3: slot index (0..CE_DIV-1) on which ce asserts and a write is launched.
- NCH, 2: number of write sources (>=1).
- ADDR_W, 22: address width.
- DATA_W, 8: data width.
- DEPTH, 4: shared FIFO depth, power of two, >=2.

Ports:
- clk  in  1  system clock (21 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  suppresses ce (core held); slot counter keeps running.
- ce  out  1  core clock-enable, one cycle per period.
- slot  out  clog2(CE_DIV)  current slot counter value.
- src_wr  in  NCH  per-channel one-cycle write strobe.
- src_addr  in  NCH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W].
- src_data  in  NCH*DATA_W  per-channel data, packed likewise.
- src_ready  out  NCH  channel holding register empty.
- mem_we  out  1  SDRAM write request.
- mem_addr  out  ADDR_W  SDRAM write address.
- mem_din  out  DATA_W  SDRAM write data.
- pending  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a strobe arrived while its holding register was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset values: slot=0, ce=0, mem_we=0, mem_addr=0, mem_din=0, pending=0, overflow=0, all holding registers empty (src_ready all 1).
- Slot counter:
  - Increments every clk; wraps CE_DIV-1 -> 0.
  - ce is combinational: (slot==CE_PHASE) && !hold.
- Channel capture:
  - src_wr[i] with holding register i empty latches addr/data next edge; src_ready[i] drops the following cycle.
  - src_wr[i] with holding register i full: data discarded, overflow set next edge.
  - Strobe on the same cycle the register drains: the strobe is accepted (drain has priority, then capture).
- Arbitration:
  - Each cycle, at most one full holding register moves to the FIFO when FIFO is not full.
  - Fixed priority: lowest index wins.
  - Transfer empties that register; src_ready rises next cycle.
  - FIFO full: nothing moves; registers stay full.
- Launch:
  - On a clk edge where slot==CE_PHASE (independent of hold), mem_we <= FIFO non-empty.
  - If non-empty, mem_addr/mem_din <= FIFO head and head is popped.
  - Otherwise mem_addr/mem_din retain their values.
  - Outputs remain stable for the full CE_DIV cycles until the next launch edge, so SDRAM sampling on its clkref is guaranteed.
- Throughput and latency:
  - One write per CE_DIV cycles.
  - Minimum latency strobe -> mem_we is 3 cycles: capture, transfer, launch on slot edge.
- Simultaneous push/pop on a FIFO-full cycle: pop happens, push of a new entry is allowed in the same cycle; pending unchanged.
- pending: push-only +1, pop-only -1, both unchanged; never exceeds DEPTH.
- overflow: set has priority over clr_overflow in the same cycle.
- Reset mid-operation: all queued and held writes are lost, and mem_we drops immediately (asynchronous).

Decomposition:
- Shared package: clog2 function, slot-width and pointer-width localparam helpers, packed-vector slice macros for channel buses.
- One sub-module: sync_fifo, a parametrised DEPTH x (ADDR_W+DATA_W) register FIFO with push/pop/full/empty/count.
- Arbiter and slot counter stay inline.

Test Plan:
- Reset release, no strobes: ce pulses at slot 3 every 4 cycles; mem_we stays 0; pending=0; src_ready=2'b11.
- Single strobe, ch0, addr 0x000010, data 0xA5, at slot 0: mem_we=1 from the slot-3 edge, addr/data stable 4 cycles; then mem_we=0; pending back to 0.
- Both channels strobe the same cycle (ch0 0x100/0x11, ch1 0x200/0x22): ch0 written in the first period, ch1 in the next; overflow=0.
- Ch0 strobes every cycle for 8 cycles with DEPTH=4:
  - FIFO fills, pending=4, src_ready[0] held low.
  - The extra strobes set overflow.
  - Accepted writes emerge in order, one per period.
- hold=1 for 3 periods with 2 queued writes: ce stays 0; both writes still launch on slot-3 edges.
- Reset asserted while mem_we=1 and pending=2: mem_we, pending and overflow go to 0 asynchronously; no write after release until a new strobe.

Source files
------------

// File: rtl/ce_write_scheduler_pkg.sv
// ce_write_scheduler_pkg: sizing helpers and channel-bus slice macro shared by the write scheduler
`ifndef CE_WRITE_SCHEDULER_PKG_SV
`define CE_WRITE_SCHEDULER_PKG_SV
`define CE_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
package ce_write_scheduler_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int slot_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
  function automatic int ptr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage
`endif

// File: rtl/ce_write_scheduler_sync_fifo.sv
// sync_fifo: register FIFO that accepts a push while full when a pop happens in the same cycle
module sync_fifo import ce_write_scheduler_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = 30
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_din,
  output logic [W-1:0]          o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ptr_w(DEPTH):0] o_count
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == L_DEPTH;
  assign o_count = r_cnt;
  assign o_dout = r_mem[r_rp];
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/ce_write_scheduler.sv
// ce_write_scheduler: divided clock-enable plus multi-source write queue issuing one SDRAM write per CE period
module ce_write_scheduler import ce_write_scheduler_pkg::*; #(
  parameter int CE_DIV = 4,
  parameter int CE_PHASE = 3,
  parameter int NCH = 2,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  output logic                     ce,
  output logic [slot_w(CE_DIV)-1:0] slot,
  input  logic [NCH-1:0]           src_wr,
  input  logic [NCH*ADDR_W-1:0]    src_addr,
  input  logic [NCH*DATA_W-1:0]    src_data,
  output logic [NCH-1:0]           src_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  output logic [ptr_w(DEPTH):0]    pending,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int SW = slot_w(CE_DIV);
  localparam int W = ADDR_W + DATA_W;
  logic [SW-1:0] r_slot;
  logic [NCH-1:0] r_full, w_drain, w_cap;
  logic [W-1:0] r_hold [NCH];
  logic [W-1:0] w_din, w_head;
  logic w_launch, w_pop, w_push, w_full, w_empty;
  assign w_launch = r_slot == SW'(CE_PHASE);
  assign w_pop = w_launch && !w_empty;
  assign ce = w_launch && !hold;
  assign slot = r_slot;
  assign src_ready = ~r_full;
  // Lowest full channel wins; a pop on this edge frees room for it even when the FIFO is full.
  always_comb begin
    w_drain = '0;
    w_din = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (r_full[i]) begin
        w_drain = '0;
        w_drain[i] = 1'b1;
        w_din = r_hold[i];
      end
    if (w_full && !w_pop) w_drain = '0;
  end
  assign w_push = |w_drain;
  assign w_cap = src_wr & (~r_full | w_drain);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_slot <= '0;
      r_full <= '0;
      overflow <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
    end else begin
      r_slot <= (r_slot == SW'(CE_DIV - 1)) ? '0 : r_slot + 1'b1;
      r_full <= (r_full & ~w_drain) | w_cap;
      overflow <= |(src_wr & ~w_cap) || (overflow && !clr_overflow);
      if (w_launch) begin
        mem_we <= !w_empty;
        if (!w_empty) {mem_addr, mem_din} <= w_head;
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      if (w_cap[i]) r_hold[i] <= {`CE_SLICE(src_addr, i, ADDR_W), `CE_SLICE(src_data, i, DATA_W)};
  sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(w_din),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(pending)
  );
endmodule

// File: tb/tb_ce_write_scheduler.sv
// tb_ce_write_scheduler: random and directed stimulus against a queue-based reference model
module tb_ce_write_scheduler;
  localparam int CE_DIV = 4, CE_PHASE = 3, NCH = 2, ADDR_W = 22, DATA_W = 8, DEPTH = 4;
  localparam int W = ADDR_W + DATA_W;
  logic clk = 0, reset = 1, hold = 0, clr_overflow = 0;
  logic ce, mem_we, overflow;
  logic [1:0] slot;
  logic [NCH-1:0] src_wr = '0, src_ready;
  logic [NCH*ADDR_W-1:0] src_addr = '0;
  logic [NCH*DATA_W-1:0] src_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [2:0] pending;
  int n_chk = 0, n_pass = 0;
  int m_slot;
  bit m_we, m_ovf;
  bit hf [NCH];
  logic [W-1:0] hv [NCH];
  logic [W-1:0] q [$];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;

  ce_write_scheduler #(.CE_DIV(CE_DIV), .CE_PHASE(CE_PHASE), .NCH(NCH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hold(hold), .ce(ce), .slot(slot), .src_wr(src_wr),
    .src_addr(src_addr), .src_data(src_data), .src_ready(src_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .pending(pending), .overflow(overflow),
    .clr_overflow(clr_overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_slot = 0; m_we = 0; m_ovf = 0; m_addr = '0; m_din = '0;
    q.delete();
    for (int i = 0; i < NCH; i++) hf[i] = 0;
  endfunction

  function automatic void step();
    bit pop, set;
    int sel;
    pop = (m_slot == CE_PHASE) && q.size() > 0;
    if (m_slot == CE_PHASE) begin
      m_we = q.size() > 0;
      if (m_we) {m_addr, m_din} = q[0];
    end
    sel = -1;
    for (int i = NCH - 1; i >= 0; i--) if (hf[i]) sel = i;
    if (pop) void'(q.pop_front());
    if (sel >= 0 && q.size() < DEPTH) begin
      q.push_back(hv[sel]);
      hf[sel] = 0;
    end
    set = 0;
    for (int i = 0; i < NCH; i++)
      if (src_wr[i]) begin
        if (!hf[i]) begin
          hf[i] = 1;
          hv[i] = {src_addr[i*ADDR_W +: ADDR_W], src_data[i*DATA_W +: DATA_W]};
        end else set = 1;
      end
    m_ovf = set || (m_ovf && !clr_overflow);
    m_slot = (m_slot + 1) % CE_DIV;
  endfunction

  task automatic check_all();
    logic [NCH-1:0] rdy;
    bit m_ce;
    for (int i = 0; i < NCH; i++) rdy[i] = !hf[i];
    m_ce = (m_slot == CE_PHASE) && !hold;
    chk("slot", 64'(slot), 64'(m_slot));
    chk("ce", 64'(ce), 64'(m_ce));
    chk("src_ready", 64'(src_ready), 64'(rdy));
    chk("mem_we", 64'(mem_we), 64'(m_we));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_din", 64'(mem_din), 64'(m_din));
    chk("pending", 64'(pending), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic cyc(input logic [1:0] wr, input logic [43:0] a, input logic [15:0] d,
                     input logic h, input logic c);
    src_wr = wr; src_addr = a; src_data = d; hold = h; clr_overflow = c;
    @(posedge clk);
    step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_slot", 64'(slot), 64'(0));
    chk("rst_ready", 64'(src_ready), 64'(2'b11));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    src_wr = '0; hold = 0; clr_overflow = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0] wr;
    int pct;
    model_reset();
    #1;
    do_reset();
    repeat (8) cyc(2'b00, '0, '0, 0, 0);
    cyc(2'b01, {22'h0, 22'h000010}, {8'h0, 8'hA5}, 0, 0);
    repeat (11) cyc(2'b00, '0, '0, 0, 0);
    cyc(2'b11, {22'h000200, 22'h000100}, {8'h22, 8'h11}, 0, 0);
    repeat (12) cyc(2'b00, '0, '0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(2'b01, {22'h0, 22'(32'h300 + i)}, {8'h0, 8'(8'h40 + i)}, 0, 0);
    repeat (40) cyc(2'b00, '0, '0, 0, 0);
    cyc(2'b00, '0, '0, 0, 1);
    cyc(2'b11, {22'h000501, 22'h000500}, {8'h51, 8'h50}, 1, 0);
    repeat (12) cyc(2'b00, '0, '0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(2'b01, {22'h0, 22'(32'h600 + i)}, {8'h0, 8'(8'h60 + i)}, 0, 0);
    repeat (5) cyc(2'b00, '0, '0, 0, 0);
    #3;
    do_reset();
    repeat (10) cyc(2'b00, '0, '0, 0, 0);
    for (int i = 0; i < 1600; i++) begin
      case ((i / 100) % 4)
        0: pct = 10;
        1: pct = 30;
        2: pct = 60;
        default: pct = 95;
      endcase
      for (int k = 0; k < NCH; k++) wr[k] = $urandom_range(99) < pct;
      r = {$urandom(), $urandom()};
      cyc(wr, r[43:0], r[59:44], $urandom_range(7) == 0, $urandom_range(15) == 0);
      if (i % 400 == 399) begin
        #2;
        do_reset();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
